// File: rtl/sgm_pkg.sv
// Shared constants and types for the SGM census front end.
package sgm_pkg;
    localparam int CENSUS_W   = 24;
    localparam int DISP_LEVEL = 32;
    localparam int IMAGE_W    = 640;
    localparam int IMAGE_H    = 480;
    localparam int COL_W      = $clog2(IMAGE_W);
    localparam int ROW_W      = $clog2(IMAGE_H);
    localparam int DISP_W     = $clog2(DISP_LEVEL);

    typedef logic [CENSUS_W-1:0] census_t;
endpackage

// File: rtl/census_window_shifter.sv
// Sliding window of right-image census vectors; slot 0 is the newest sample.
module census_window_shifter
    import sgm_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 shift,
    input  logic                                 clear_tail,
    input  census_t                              din,
    output logic [DISP_LEVEL-1:0][CENSUS_W-1:0]  window
);
    logic [DISP_LEVEL-1:0][CENSUS_W-1:0] window_q, window_d;

    // A line start flushes the older slots so no census from the previous line leaks in.
    always_comb begin
        window_d = window_q;
        if (shift) begin
            window_d[0] = din;
            for (int d = 1; d < DISP_LEVEL; d++)
                window_d[d] = clear_tail ? '0 : window_q[d-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) window_q <= '0;
        else     window_q <= window_d;
    end

    assign window = window_q;
endmodule

// File: rtl/census_disp_feeder.sv
// Builds PixData / LineData / IsOnEdge for the SGM core from a raster census stream.
module census_disp_feeder
    import sgm_pkg::*;
#(
    parameter int ImageW = IMAGE_W,
    parameter int ImageH = IMAGE_H
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [CENSUS_W-1:0]            left_census,
    input  logic [CENSUS_W-1:0]            right_census,
    output logic                           out_en,
    output logic [CENSUS_W-1:0]            PixData,
    output logic [CENSUS_W*DISP_LEVEL-1:0] LineData,
    output logic                           IsOnEdge,
    output logic                           frame_done,
    output logic                           sof_err
);
    localparam int CW = $clog2(ImageW);
    localparam int RW = $clog2(ImageH);
    localparam logic [CW-1:0] COL_LAST = CW'(ImageW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ImageH - 1);

    logic [CW-1:0] col_q, col_d, pix_col;
    logic [RW-1:0] row_q, row_d, pix_row;
    logic          edge_d, last_d, serr_d;

    logic          out_en_q, edge_q, fdone_q, serr_q;
    census_t       pix_q;
    logic [DISP_LEVEL-1:0][CENSUS_W-1:0] window;

    // in_sof overrides the counters for the current pixel; counting resumes from (0,0).
    always_comb begin
        pix_col = in_sof ? '0 : col_q;
        pix_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
        end
        edge_d = (pix_row == '0) || (pix_col == '0) || (pix_col == COL_LAST);
        last_d = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
        serr_d = in_sof && ((col_q != '0) || (row_q != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            out_en_q <= 1'b0;
            pix_q    <= '0;
            edge_q   <= 1'b0;
            fdone_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            out_en_q <= in_valid;
            fdone_q  <= in_valid && last_d;
            serr_q   <= in_valid && serr_d;
            if (in_valid) begin
                pix_q  <= left_census;
                edge_q <= edge_d;
            end
        end
    end

    census_window_shifter u_window (
        .clk        (clk),
        .rst        (rst),
        .shift      (in_valid),
        .clear_tail (pix_col == '0),
        .din        (right_census),
        .window     (window)
    );

    assign out_en     = out_en_q;
    assign PixData    = pix_q;
    assign LineData   = window;
    assign IsOnEdge   = edge_q;
    assign frame_done = fdone_q;
    assign sof_err    = serr_q;
endmodule

// File: tb/tb_census_disp_feeder.sv
// Directed bench for census_disp_feeder on a reduced 64x16 frame.
module tb_census_disp_feeder;
    import sgm_pkg::*;

    localparam int W  = 64;
    localparam int H  = 16;
    localparam int LW = CENSUS_W * DISP_LEVEL;

    logic                clk = 1'b0;
    logic                rst, in_valid, in_sof;
    logic [CENSUS_W-1:0] left_census, right_census;
    logic                out_en, IsOnEdge, frame_done, sof_err;
    logic [CENSUS_W-1:0] PixData;
    logic [LW-1:0]       LineData;

    census_disp_feeder #(.ImageW(W), .ImageH(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .left_census  (left_census),
        .right_census (right_census),
        .out_en       (out_en),
        .PixData      (PixData),
        .LineData     (LineData),
        .IsOnEdge     (IsOnEdge),
        .frame_done   (frame_done),
        .sof_err      (sof_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference: per-line buffer of right census indexed by column.
    int                  ecol, erow, seq;
    logic [CENSUS_W-1:0] rline [W];
    logic [CENSUS_W-1:0] e_pix, last_r;
    logic [LW-1:0]       e_line;
    logic                e_edge, e_fd, e_err;

    int   oe_cnt = 0, fd_cnt = 0;
    logic count_en = 1'b0;

    always @(negedge clk) begin
        if (count_en) begin
            if (out_en)     oe_cnt++;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        ecol = 0; erow = 0;
        for (int i = 0; i < W; i++) rline[i] = '0;
        e_pix = '0; e_line = '0; e_edge = 1'b0; e_fd = 1'b0; e_err = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".en"},   out_en,     '0);
        chk({tag, ".pix"},  PixData,    '0);
        chk({tag, ".line"}, LineData,   '0);
        chk({tag, ".edge"}, IsOnEdge,   '0);
        chk({tag, ".fd"},   frame_done, '0);
        chk({tag, ".err"},  sof_err,    '0);
    endtask

    task automatic pix(input logic sof, input logic [CENSUS_W-1:0] r, input logic [CENSUS_W-1:0] l,
                       input string tag);
        int pc, pr;
        e_err = sof && (ecol != 0 || erow != 0);
        pc = sof ? 0 : ecol;
        pr = sof ? 0 : erow;
        rline[pc] = r;
        e_pix  = l;
        e_edge = (pr == 0) || (pc == 0) || (pc == W - 1);
        e_fd   = (pc == W - 1) && (pr == H - 1);
        e_line = '0;
        for (int d = 0; d < DISP_LEVEL; d++)
            if (pc >= d) e_line[d*CENSUS_W +: CENSUS_W] = rline[pc-d];
        if (pc == W - 1) begin
            ecol = 0;
            erow = (pr == H - 1) ? 0 : pr + 1;
        end else begin
            ecol = pc + 1;
            erow = pr;
        end
        in_valid = 1'b1; in_sof = sof; right_census = r; left_census = l;
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        chk({tag, ".en"},   out_en,     1'b1);
        chk({tag, ".pix"},  PixData,    e_pix);
        chk({tag, ".line"}, LineData,   e_line);
        chk({tag, ".edge"}, IsOnEdge,   e_edge);
        chk({tag, ".fd"},   frame_done, e_fd);
        chk({tag, ".err"},  sof_err,    e_err);
    endtask

    task automatic adv(input logic sof, input string tag);
        seq++;
        last_r = right_census;
        pix(sof, 24'h5A0000 + CENSUS_W'(seq), 24'hC30000 ^ CENSUS_W'(seq), tag);
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".en"},   out_en,     1'b0);
        chk({tag, ".pix"},  PixData,    e_pix);
        chk({tag, ".line"}, LineData,   e_line);
        chk({tag, ".fd"},   frame_done, 1'b0);
        chk({tag, ".err"},  sof_err,    1'b0);
    endtask

    initial begin
        int guard;
        seq = 0;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        left_census = '0; right_census = '0;
        reset_model();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // 1: first four pixels of the frame
        pix(1'b0, 24'd1, 24'hA1, "t1.p0");
        pix(1'b0, 24'd2, 24'hA2, "t1.p1");
        pix(1'b0, 24'd3, 24'hA3, "t1.p2");
        pix(1'b0, 24'd4, 24'hA4, "t1.p3");
        chk("t1.slots0_3", LineData[95:0], {24'd1, 24'd2, 24'd3, 24'd4});
        chk("t1.tail", LineData[LW-1:96], '0);
        chk("t1.edge", IsOnEdge, 1'b1);

        // 2: interior and right-edge pixels, line-start clear
        guard = 0;
        while (!(erow == 2 && ecol == 5) && guard < 5000) begin adv(1'b0, "t2.run"); guard++; end
        chk("t2.reach", guard < 5000, 1'b1);
        adv(1'b0, "t2.c5");
        chk("t2.interior", IsOnEdge, 1'b0);
        while (ecol != W - 1) adv(1'b0, "t2.run");
        adv(1'b0, "t2.clast");
        chk("t2.rightedge", IsOnEdge, 1'b1);
        adv(1'b0, "t2.r3c0");
        chk("t2.tailclr", LineData[LW-1:CENSUS_W], '0);

        // 4: in_sof mid-line
        while (ecol != 10) adv(1'b0, "t4.run");
        adv(1'b1, "t4.sof");
        chk("t4.err", sof_err, 1'b1);
        chk("t4.edge", IsOnEdge, 1'b1);
        chk("t4.tail", LineData[LW-1:CENSUS_W], '0);
        adv(1'b0, "t4.next");
        chk("t4.noerr", sof_err, 1'b0);
        chk("t4.slot1", LineData[2*CENSUS_W-1:CENSUS_W], last_r);

        // 6: input stall mid-line
        while (ecol != 20) adv(1'b0, "t6.run");
        for (int i = 0; i < 10; i++) idle("t6.stall");
        adv(1'b0, "t6.resume");
        adv(1'b0, "t6.resume2");

        // 5: reset mid-line
        while (ecol != 30) adv(1'b0, "t5.run");
        rst = 1'b1;
        @(negedge clk);
        chk_zero("t5.rst");
        rst = 1'b0;
        reset_model();
        adv(1'b0, "t5.first");
        chk("t5.edge", IsOnEdge, 1'b1);
        chk("t5.err", sof_err, 1'b0);

        // 3: full frame with random gaps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        oe_cnt = 0; fd_cnt = 0; count_en = 1'b1;
        for (int i = 0; i < W * H; i++) begin
            adv(i == 0, "t3.px");
            if ($urandom_range(1) == 1) idle("t3.gap");
        end
        idle("t3.drain");
        count_en = 1'b0;
        chk("t3.out_en_count", oe_cnt, W * H);
        chk("t3.frame_done_count", fd_cnt, 1);
        adv(1'b1, "t3.next_sof");
        chk("t3.next_err", sof_err, 1'b0);
        chk("t3.next_edge", IsOnEdge, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
